// File: rtl/rc4_encrypt.sv
// rtl/rc4_encrypt.sv - single-key RC4 encryptor: KSA over an internal S RAM, then keystream XOR from plaintext RAM to ciphertext RAM
module rc4_encrypt #(
  parameter int MSG_LEN = 32
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] key,
  output logic        busy,
  output logic        done,
  output logic        bad_char,
  output logic [4:0]  p_address,
  input  logic [7:0]  p_q,
  output logic [4:0]  c_address,
  output logic [7:0]  c_data,
  output logic        c_wren
);

  typedef enum logic [4:0] {
    IDLE, FILL,
    S_READ_I, S_WAIT_I, S_COMPUTE_J, S_WAIT_J, S_WRITE_I, S_WRITE_J,
    E_INIT, E_INC_I, E_WAIT_I, E_COMPUTE_J, E_WAIT_J, E_WRITE_I, E_WRITE_J,
    E_READ_F, E_WAIT_F, E_WRITE_OUT,
    DONE
  } state_t;

  localparam logic [7:0] LAST_K = 8'(MSG_LEN - 1);

  state_t      state;
  logic [7:0]  i, j, k;
  logic [7:0]  data_i, data_j, data_f;
  logic [7:0]  rd_addr;
  logic [23:0] key_q;
  logic [1:0]  key_idx;
  logic [7:0]  key_byte;
  logic [7:0]  j_ksa, j_prga;
  logic        p_text;

  logic [7:0]  s_mem [256];
  logic [7:0]  s_q, s_addr, s_wdata;
  logic        s_wren;

  // key_idx tracks i mod 3 so no divider is needed
  always_comb begin
    case (key_idx)
      2'd0:    key_byte = key_q[23:16];
      2'd1:    key_byte = key_q[15:8];
      default: key_byte = key_q[7:0];
    endcase
  end

  assign j_ksa  = j + s_q + key_byte;
  assign j_prga = j + s_q;
  assign data_f = s_q;
  assign p_text = (p_q == 8'd32) || ((p_q >= 8'd97) && (p_q <= 8'd122));

  // Reads use the registered rd_addr so the address is stable through the wait state
  always_comb begin
    s_addr  = rd_addr;
    s_wdata = data_i;
    s_wren  = 1'b0;
    case (state)
      FILL: begin
        s_addr  = i;
        s_wdata = i;
        s_wren  = 1'b1;
      end
      S_WRITE_I, E_WRITE_I: begin
        s_addr  = i;
        s_wdata = s_q;
        s_wren  = 1'b1;
      end
      S_WRITE_J, E_WRITE_J: begin
        s_addr  = j;
        s_wdata = data_i;
        s_wren  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (s_wren) s_mem[s_addr] <= s_wdata;
    s_q <= s_mem[s_addr];
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      bad_char  <= 1'b0;
      c_wren    <= 1'b0;
      p_address <= 5'd0;
      c_address <= 5'd0;
      c_data    <= 8'd0;
      i         <= 8'd0;
      j         <= 8'd0;
      k         <= 8'd0;
      data_i    <= 8'd0;
      data_j    <= 8'd0;
      rd_addr   <= 8'd0;
      key_q     <= 24'd0;
      key_idx   <= 2'd0;
    end else begin
      done   <= 1'b0;
      c_wren <= 1'b0;
      case (state)
        IDLE: if (start) begin
          key_q    <= key;
          bad_char <= 1'b0;
          i        <= 8'd0;
          j        <= 8'd0;
          key_idx  <= 2'd0;
          busy     <= 1'b1;
          state    <= FILL;
        end
        FILL: begin
          i <= i + 8'd1;
          if (i == 8'hFF) state <= S_READ_I;
        end
        S_READ_I: begin
          rd_addr <= i;
          state   <= S_WAIT_I;
        end
        S_WAIT_I: state <= S_COMPUTE_J;
        S_COMPUTE_J: begin
          data_i  <= s_q;
          j       <= j_ksa;
          rd_addr <= j_ksa;
          state   <= S_WAIT_J;
        end
        S_WAIT_J: state <= S_WRITE_I;
        S_WRITE_I: begin
          data_j <= s_q;
          state  <= S_WRITE_J;
        end
        S_WRITE_J: begin
          key_idx <= (key_idx == 2'd2) ? 2'd0 : key_idx + 2'd1;
          if (i == 8'hFF) begin
            state <= E_INIT;
          end else begin
            i     <= i + 8'd1;
            state <= S_READ_I;
          end
        end
        E_INIT: begin
          i     <= 8'd0;
          j     <= 8'd0;
          k     <= 8'd0;
          state <= E_INC_I;
        end
        E_INC_I: begin
          i       <= i + 8'd1;
          rd_addr <= i + 8'd1;
          state   <= E_WAIT_I;
        end
        E_WAIT_I: state <= E_COMPUTE_J;
        E_COMPUTE_J: begin
          data_i  <= s_q;
          j       <= j_prga;
          rd_addr <= j_prga;
          state   <= E_WAIT_J;
        end
        E_WAIT_J: state <= E_WRITE_I;
        E_WRITE_I: begin
          data_j <= s_q;
          state  <= E_WRITE_J;
        end
        E_WRITE_J: state <= E_READ_F;
        E_READ_F: begin
          rd_addr   <= data_i + data_j;
          p_address <= k[4:0];
          state     <= E_WAIT_F;
        end
        E_WAIT_F: state <= E_WRITE_OUT;
        E_WRITE_OUT: begin
          c_address <= k[4:0];
          c_data    <= p_q ^ data_f;
          c_wren    <= 1'b1;
          if (!p_text) bad_char <= 1'b1;
          if (k == LAST_K) begin
            state <= DONE;
          end else begin
            k     <= k + 8'd1;
            state <= E_INC_I;
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_encrypt.sv
// tb/tb_rc4_encrypt.sv - directed self-checking bench for rc4_encrypt (MSG_LEN 9 and 32 instances)
module tb_rc4_encrypt;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start9, busy9, done9, bad9, c_wren9;
  logic [23:0] key9;
  logic [4:0]  p_addr9, c_addr9;
  logic [7:0]  p_q9, c_data9;
  logic        start32, busy32, done32, bad32, c_wren32;
  logic [23:0] key32;
  logic [4:0]  p_addr32, c_addr32;
  logic [7:0]  p_q32, c_data32;

  rc4_encrypt #(.MSG_LEN(9)) dut9 (
    .CLOCK_50(clk), .reset(reset), .start(start9), .key(key9),
    .busy(busy9), .done(done9), .bad_char(bad9),
    .p_address(p_addr9), .p_q(p_q9),
    .c_address(c_addr9), .c_data(c_data9), .c_wren(c_wren9)
  );

  rc4_encrypt #(.MSG_LEN(32)) dut32 (
    .CLOCK_50(clk), .reset(reset), .start(start32), .key(key32),
    .busy(busy32), .done(done32), .bad_char(bad32),
    .p_address(p_addr32), .p_q(p_q32),
    .c_address(c_addr32), .c_data(c_data32), .c_wren(c_wren32)
  );

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  logic [7:0] pt9  [32];
  logic [7:0] pt32 [32];
  logic [7:0] m_pt [32];
  logic [7:0] m_ct [32];

  int          wr_cnt9 = 0, done_cnt9 = 0, done_cyc9 = 0;
  logic [12:0] wlog9 [512];
  int          wr_cnt32 = 0, done_cnt32 = 0, done_cyc32 = 0, rise_cyc32 = 0;
  logic [12:0] wlog32 [512];
  logic        bad_at_done32 = 1'b0;
  logic        busy32_d = 1'b0;

  // plaintext RAMs: one-cycle registered read
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    p_q9  <= pt9[p_addr9];
    p_q32 <= pt32[p_addr32];
  end

  // write/done monitors on the inactive edge
  always @(negedge clk) begin
    if (c_wren9) begin
      wlog9[wr_cnt9 & 511] <= {c_addr9, c_data9};
      wr_cnt9 <= wr_cnt9 + 1;
    end
    if (done9) begin
      done_cnt9 <= done_cnt9 + 1;
      done_cyc9 <= cyc;
    end
    if (c_wren32) begin
      wlog32[wr_cnt32 & 511] <= {c_addr32, c_data32};
      wr_cnt32 <= wr_cnt32 + 1;
    end
    if (done32) begin
      done_cnt32    <= done_cnt32 + 1;
      done_cyc32    <= cyc;
      bad_at_done32 <= bad32;
    end
    if (busy32 && !busy32_d) rise_cyc32 <= cyc;
    busy32_d <= busy32;
  end

  // reference RC4, written independently of the hardware schedule
  task automatic rc4_model(input logic [23:0] kk, input int n);
    logic [7:0] s [256];
    logic [7:0] kb [3];
    logic [7:0] a, b, t;
    kb[0] = kk[23:16];
    kb[1] = kk[15:8];
    kb[2] = kk[7:0];
    for (int x = 0; x < 256; x++) s[x] = 8'(x);
    b = 8'd0;
    for (int x = 0; x < 256; x++) begin
      b = b + s[x] + kb[x % 3];
      t = s[x]; s[x] = s[b]; s[b] = t;
    end
    a = 8'd0;
    b = 8'd0;
    for (int x = 0; x < n; x++) begin
      a = a + 8'd1;
      b = b + s[a];
      t = s[a]; s[a] = s[b]; s[b] = t;
      t = s[a] + s[b];
      m_ct[x] = m_pt[x] ^ s[t];
    end
  endtask

  task automatic load_pt9(input string s);
    for (int x = 0; x < 32; x++) pt9[x] = (x < s.len()) ? s[x] : 8'h20;
  endtask

  task automatic load_pt32(input string s);
    for (int x = 0; x < 32; x++) begin
      pt32[x] = (x < s.len()) ? s[x] : 8'h20;
      m_pt[x] = pt32[x];
    end
  endtask

  task automatic start_run9(input logic [23:0] kk, output int e);
    @(negedge clk);
    key9 = kk; start9 = 1'b1; e = cyc + 1;
    @(negedge clk);
    start9 = 1'b0;
  endtask

  task automatic start_run32(input logic [23:0] kk, output int e);
    @(negedge clk);
    key32 = kk; start32 = 1'b1; e = cyc + 1;
    @(negedge clk);
    start32 = 1'b0;
  endtask

  task automatic wait_done9(input int base, input string tag);
    int t = 0;
    while (done_cnt9 == base && t < 4000) begin @(posedge clk); t++; end
    checks++;
    if (done_cnt9 == base) begin
      errors++; $display("FAIL %s done timeout: got no done, want one within 4000 cycles", tag);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_done32(input int base, input string tag);
    int t = 0;
    while (done_cnt32 == base && t < 4000) begin @(posedge clk); t++; end
    checks++;
    if (done_cnt32 == base) begin
      errors++; $display("FAIL %s done timeout: got no done, want one within 4000 cycles", tag);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; start9 = 1'b0; start32 = 1'b0; key9 = 24'd0; key32 = 24'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy9, done9, c_wren9, bad9, p_addr9, c_addr9, c_data9} !== 22'd0) begin
      errors++; $display("FAIL reset9 outputs got %h want 0", {busy9, done9, c_wren9, bad9, p_addr9, c_addr9, c_data9});
    end
    checks++;
    if ({busy32, done32, c_wren32, bad32, p_addr32, c_addr32, c_data32} !== 22'd0) begin
      errors++; $display("FAIL reset32 outputs got %h want 0", {busy32, done32, c_wren32, bad32, p_addr32, c_addr32, c_data32});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_known_vector(input string tag);
    logic [71:0] v1;
    int e, bw, bd;
    v1 = 72'hBBF316E8D940AF0AD3;
    load_pt9("Plaintext");
    bw = wr_cnt9; bd = done_cnt9;
    start_run9(24'h4B6579, e);
    wait_done9(bd, tag);
    checks++;
    if (done_cyc9 - e !== 1875) begin
      errors++; $display("FAIL %s done latency got %0d want 1875", tag, done_cyc9 - e);
    end
    checks++;
    if (wr_cnt9 - bw !== 9) begin
      errors++; $display("FAIL %s write count got %0d want 9", tag, wr_cnt9 - bw);
    end
    for (int n = 0; n < 9; n++) begin
      checks++;
      if (wlog9[(bw + n) & 511] !== {5'(n), v1[71 - 8*n -: 8]}) begin
        errors++; $display("FAIL %s byte %0d got addr/data %h want %h", tag, n, wlog9[(bw + n) & 511], {5'(n), v1[71 - 8*n -: 8]});
      end
    end
    checks++;
    if (bad9 !== 1'b1) begin
      errors++; $display("FAIL %s bad_char got %b want 1", tag, bad9);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (done_cnt9 - bd !== 1) begin
      errors++; $display("FAIL %s done pulses got %0d want 1", tag, done_cnt9 - bd);
    end
  endtask

  task automatic test_roundtrip;
    int e, bw, bd;
    load_pt32("attack at dawn");
    rc4_model(24'h000249, 32);
    bw = wr_cnt32; bd = done_cnt32;
    start_run32(24'h000249, e);
    wait_done32(bd, "rt_enc");
    checks++;
    if (done_cyc32 - e !== 2082) begin
      errors++; $display("FAIL rt_latency got %0d want 2082", done_cyc32 - e);
    end
    checks++;
    if (bad_at_done32 !== 1'b0) begin
      errors++; $display("FAIL rt_bad_char got %b want 0", bad_at_done32);
    end
    checks++;
    if (wr_cnt32 - bw !== 32) begin
      errors++; $display("FAIL rt_write_count got %0d want 32", wr_cnt32 - bw);
    end
    for (int n = 0; n < 32; n++) begin
      checks++;
      if (wlog32[(bw + n) & 511] !== {5'(n), m_ct[n]}) begin
        errors++; $display("FAIL rt_enc byte %0d got %h want %h", n, wlog32[(bw + n) & 511], {5'(n), m_ct[n]});
      end
      pt32[n] = wlog32[(bw + n) & 511][7:0];
    end
    bw = wr_cnt32; bd = done_cnt32;
    start_run32(24'h000249, e);
    wait_done32(bd, "rt_dec");
    for (int n = 0; n < 32; n++) begin
      checks++;
      if (wlog32[(bw + n) & 511][7:0] !== m_pt[n]) begin
        errors++; $display("FAIL rt_dec byte %0d got %h want %h", n, wlog32[(bw + n) & 511][7:0], m_pt[n]);
      end
    end
  endtask

  task automatic test_key_order;
    logic [7:0]  r1 [32];
    logic [23:0] keys [2];
    int e, bw, bd, diff;
    keys[0] = 24'h010000;
    keys[1] = 24'h000001;
    load_pt32("attack at dawn");
    for (int r = 0; r < 2; r++) begin
      rc4_model(keys[r], 32);
      bw = wr_cnt32; bd = done_cnt32;
      start_run32(keys[r], e);
      wait_done32(bd, "key_order");
      diff = 0;
      for (int n = 0; n < 32; n++) begin
        checks++;
        if (wlog32[(bw + n) & 511][7:0] !== m_ct[n]) begin
          errors++; $display("FAIL key_order key %h byte %0d got %h want %h", keys[r], n, wlog32[(bw + n) & 511][7:0], m_ct[n]);
        end
        if (r == 0) r1[n] = wlog32[(bw + n) & 511][7:0];
        else if (r1[n] !== wlog32[(bw + n) & 511][7:0]) diff++;
      end
    end
    checks++;
    if (diff == 0) begin
      errors++; $display("FAIL key_order_distinct got 0 differing bytes want nonzero");
    end
  endtask

  task automatic test_midrun_reset;
    int e, bw;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (bad9 !== 1'b0) begin
      errors++; $display("FAIL reset_bad_char got %b want 0", bad9);
    end
    load_pt9("Plaintext");
    start_run9(24'h4B6579, e);
    while (cyc < e + 999) @(negedge clk);
    checks++;
    if (busy9 !== 1'b1) begin
      errors++; $display("FAIL midrun_busy_before got %b want 1", busy9);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({busy9, done9, c_wren9, bad9, p_addr9, c_addr9, c_data9} !== 22'd0) begin
      errors++; $display("FAIL midrun_reset outputs got %h want 0", {busy9, done9, c_wren9, bad9, p_addr9, c_addr9, c_data9});
    end
    bw = wr_cnt9;
    repeat (1200) @(negedge clk);
    checks++;
    if (wr_cnt9 !== bw || busy9 !== 1'b0) begin
      errors++; $display("FAIL midrun_idle got writes %0d busy %b want 0 and 0", wr_cnt9 - bw, busy9);
    end
    test_known_vector("after_reset");
  endtask

  task automatic test_start_ignored;
    int e, bw, bd;
    load_pt32("attack at dawn");
    rc4_model(24'h000249, 32);
    bw = wr_cnt32; bd = done_cnt32;
    start_run32(24'h000249, e);
    while (cyc < e + 1900) @(negedge clk);
    key32 = 24'hABCDEF; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    wait_done32(bd, "ignored");
    for (int n = 0; n < 32; n++) begin
      checks++;
      if (wlog32[(bw + n) & 511][7:0] !== m_ct[n]) begin
        errors++; $display("FAIL ignored byte %0d got %h want %h", n, wlog32[(bw + n) & 511][7:0], m_ct[n]);
      end
    end
    repeat (40) @(negedge clk);
    checks++;
    if (done_cnt32 - bd !== 1 || busy32 !== 1'b0) begin
      errors++; $display("FAIL ignored_single_run got dones %0d busy %b want 1 and 0", done_cnt32 - bd, busy32);
    end
  endtask

  task automatic test_back_to_back;
    int e, bw, bd, d1;
    load_pt32("Plaintext");
    rc4_model(24'h4B6579, 32);
    bw = wr_cnt32; bd = done_cnt32;
    @(negedge clk);
    key32 = 24'h4B6579; start32 = 1'b1; e = cyc + 1;
    wait_done32(bd, "b2b_first");
    d1 = done_cyc32;
    checks++;
    if (d1 - e !== 2082) begin
      errors++; $display("FAIL b2b_latency1 got %0d want 2082", d1 - e);
    end
    checks++;
    if (rise_cyc32 !== d1 + 1 || busy32 !== 1'b1) begin
      errors++; $display("FAIL b2b_restart got busy rise %0d busy %b want %0d and 1", rise_cyc32, busy32, d1 + 1);
    end
    checks++;
    if (bad_at_done32 !== 1'b1) begin
      errors++; $display("FAIL b2b_bad1 got %b want 1", bad_at_done32);
    end
    checks++;
    if (bad32 !== 1'b0) begin
      errors++; $display("FAIL b2b_bad_cleared got %b want 0", bad32);
    end
    start32 = 1'b0;
    wait_done32(bd + 1, "b2b_second");
    checks++;
    if (done_cyc32 - (d1 + 1) !== 2082) begin
      errors++; $display("FAIL b2b_latency2 got %0d want 2082", done_cyc32 - (d1 + 1));
    end
    checks++;
    if (bad_at_done32 !== 1'b1) begin
      errors++; $display("FAIL b2b_bad2 got %b want 1", bad_at_done32);
    end
    for (int n = 0; n < 32; n++) begin
      checks++;
      if (wlog32[(bw + n) & 511][7:0] !== m_ct[n] || wlog32[(bw + 32 + n) & 511][7:0] !== m_ct[n]) begin
        errors++; $display("FAIL b2b byte %0d got %h and %h want %h", n, wlog32[(bw + n) & 511][7:0], wlog32[(bw + 32 + n) & 511][7:0], m_ct[n]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_known_vector("vector1");
    test_roundtrip();
    test_key_order();
    test_midrun_reset();
    test_start_ignored();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/rc4_encrypt.md
# rc4_encrypt

Single-key RC4 encryptor, the writer-side counterpart of the key-cracking decryptor. On `start` it runs the key-scheduling pass over an internal 256-byte S array, using a 24-bit key. It then runs the keystream generator for `MSG_LEN` bytes, reading plaintext from an external RAM and writing ciphertext to an external RAM. The output RAM has the same layout the decryptor's encrypted-message ROM is initialised from, so decryptor runs can be fed by test messages this block generates.

## Interface
- `MSG_LEN`, default 32: message length in bytes, range 1..32.
- `CLOCK_50` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: sampled only in IDLE; a high sample begins a run.
- `key` in 24: secret key; byte n is `key[23-8n -: 8]`, byte 0 = `key[23:16]`. Captured on start acceptance.
- `busy` out 1: high from the cycle after start acceptance until DONE is left.
- `done` out 1: one-cycle pulse at run completion.
- `bad_char` out 1: sticky; set if any plaintext byte is outside {32, 97..122}. Cleared on start acceptance.
- `p_address` out 5: plaintext RAM address; the RAM has a 1-cycle registered read.
- `p_q` in 8: plaintext RAM read data.
- `c_address` out 5: ciphertext RAM address.
- `c_data` out 8: ciphertext RAM write data.
- `c_wren` out 1: ciphertext RAM write enable, one cycle per byte.

## Operation
- S array: internal 256x8 RAM with synchronous write and 1-cycle registered read (inferred, same behaviour as the s_memory IP).
- Registers:
  - i, j, k: 8-bit; all i/j arithmetic is mod 256 by natural wrap.
  - data_i, data_j, data_f: 8-bit.
  - key_q: 24-bit.
- States and transitions:
  - IDLE: stays until `start`=1. Then captures `key`, clears `bad_char`, sets i=j=0 and goes to FILL.
  - FILL: writes S[n]=n for n=0..255, one write per cycle. After n=255, goes to S_READ_I.
  - KSA loop, one iteration per i:
    - S_READ_I: issues a read of S[i].
    - S_WAIT_I: no operation.
    - S_COMPUTE_J: data_i=S[i]; j=j+data_i+key_q byte (i mod 3); issues a read of S[j].
    - S_WAIT_J: no operation.
    - S_WRITE_I: data_j=S[j]; writes S[i]=data_j.
    - S_WRITE_J: writes S[j]=data_i. If i=255, goes to E_INIT; else i++ and back to S_READ_I.
  - E_INIT: sets i=j=k=0.
  - Keystream loop, one iteration per k:
    - E_INC_I: i=i+1; issues a read of S[i].
    - E_WAIT_I: no operation.
    - E_COMPUTE_J: data_i=S[i]; j=j+data_i; issues a read of S[j].
    - E_WAIT_J: no operation.
    - E_WRITE_I: data_j=S[j]; writes S[i]=data_j.
    - E_WRITE_J: writes S[j]=data_i.
    - E_READ_F: issues a read of S[(data_i+data_j) mod 256]; drives `p_address`=k[4:0].
    - E_WAIT_F: no operation.
    - E_WRITE_OUT: data_f=S[f]. Drives `c_address`=k[4:0], `c_data`=p_q^data_f, `c_wren`=1. Sets `bad_char` if p_q is outside {32, 97..122}. If k=MSG_LEN-1, goes to DONE; else k++ and back to E_INC_I.
  - DONE: `done`=1 for this one cycle, then returns to IDLE.
- `start` in any state other than IDLE is ignored; there is no queueing.
- A non-text plaintext byte does not abort the run; it is still encrypted and written. Only `bad_char` flags it.

## Timing
- Reset: a synchronous `reset`=1 at any point, including mid-run, has these effects on the next edge:
  - state=IDLE;
  - `busy`=0, `done`=0, `c_wren`=0, `bad_char`=0;
  - `p_address`=0, `c_address`=0, `c_data`=0.
- Reset does not clear S contents; FILL reinitialises them on every run.
- Cycle counts, with E = start-acceptance edge:
  - FILL: 256 cycles.
  - KSA: 6 cycles per i, 1536 cycles total.
  - E_INIT: 1 cycle.
  - Keystream: 9 cycles per byte.
- `done` is high for exactly one cycle, starting 1794+9*MSG_LEN edges after E (2082 for MSG_LEN=32). `busy` falls on the same edge as `done`.
- `c_wren` is high only in E_WRITE_OUT, exactly MSG_LEN pulses per run, at addresses 0..MSG_LEN-1 in ascending order.
- `p_address` is valid from E_READ_F onward; `p_q` is consumed two edges later in E_WRITE_OUT.
- `start` held high continuously: a new run begins on the edge after DONE, i.e. back-to-back runs.

## Test plan
- Known vector: MSG_LEN=9, `key`=24'h4B6579 ("Key"), plaintext "Plaintext" -> ciphertext bytes BB F3 16 E8 D9 40 AF 0A D3 at c_address 0..8. `bad_char`=1 because of 'P'=0x50. `done` pulses 1875 edges after E.
- Round trip: MSG_LEN=32, `key`=24'h000249, plaintext "attack at dawn" padded with spaces -> `bad_char`=0. Re-running with the ciphertext as plaintext reproduces the original 32 bytes exactly.
- Key byte order: with a known plaintext, `key`=24'h010000 and `key`=24'h000001 produce different ciphertext, each matching a software RC4 model with key bytes {01,00,00} and {00,00,01} respectively.
- Mid-run reset: assert `reset` for 1 cycle during the KSA (1000 edges after E) -> next cycle IDLE, `busy`=0, no `c_wren`. A new `start` then yields correct vector-1 output.
- `start` ignored while busy: pulse `start` with a different `key` during the keystream phase -> output unchanged from the original key; exactly one `done`.
- Back-to-back runs: hold `start`=1 -> second `busy` period begins the edge after the first `done`. Both outputs are identical, and `bad_char` is cleared and re-evaluated on each run.
